// File: rtl/count_monitor_pkg.sv
// Shared types and default widths for the count_monitor slice.
// Imported by sat_counter and count_monitor.
package count_monitor_pkg;

    typedef enum logic [1:0] {
        HUNT,
        TRACK,
        FAULT
    } mon_state_t;

    localparam int DEF_W      = 4;
    localparam int DEF_LOCK_N = 2;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared by R (async) or clr.
// Ports: clk, R (async active-low), clr (sync clear), inc, q.
module sat_counter
    import count_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             R,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Receive-side checker for a free-running W-bit up-counter bus.
// Ports: clk, R (async active-low), clr, in_valid, in_count[W] in;
//        locked, err_pulse, err_cnt[CNT_W], wrap_cnt[CNT_W], expected[W] out.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int LOCK_N = DEF_LOCK_N,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             R,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [W-1:0]     in_count,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [W-1:0]     expected
);

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_N);

    mon_state_t       state_q, state_d;
    logic             have_prev_q, have_prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [W-1:0]     exp_q, exp_d;
    logic             pulse_q, pulse_d;
    logic             err_inc, wrap_inc;
    logic             match;
    logic [RUN_W-1:0] run_nxt;

    assign match   = (in_count == exp_q);
    assign run_nxt = run_q + RUN_W'(1);

    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        run_d       = run_q;
        exp_d       = exp_q;
        pulse_d     = 1'b0;
        err_inc     = 1'b0;
        wrap_inc    = 1'b0;
        if (clr) begin
            state_d     = HUNT;
            have_prev_d = 1'b0;
            run_d       = '0;
        end else if (in_valid) begin
            // Every accepted sample re-seeds the prediction.
            exp_d = in_count + W'(1);
            case (state_q)
                HUNT: begin
                    if (!have_prev_q) begin
                        have_prev_d = 1'b1;
                        run_d       = '0;
                    end else if (match) begin
                        if (run_nxt == RUN_TGT) begin
                            state_d = TRACK;
                            run_d   = '0;
                        end else begin
                            run_d = run_nxt;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                TRACK: begin
                    if (match) begin
                        // A matching 0 means the previous sample was all-ones.
                        wrap_inc = (in_count == '0);
                    end else begin
                        state_d = FAULT;
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                FAULT: begin
                    if (match) begin
                        state_d = TRACK;
                    end else begin
                        state_d = HUNT;
                        run_d   = '0;
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q     <= HUNT;
            have_prev_q <= 1'b0;
            run_q       <= '0;
            exp_q       <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            run_q       <= run_d;
            exp_q       <= exp_d;
            pulse_q     <= pulse_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err (
        .clk (clk),
        .R   (R),
        .clr (clr),
        .inc (err_inc),
        .q   (err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap (
        .clk (clk),
        .R   (R),
        .clr (clr),
        .inc (wrap_inc),
        .q   (wrap_cnt)
    );

    assign locked    = (state_q == TRACK);
    assign err_pulse = pulse_q;
    assign expected  = exp_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor (W=4, LOCK_N=2, CNT_W=8).
// Each scenario task drives samples and checks outputs 1ns after the edge.
module tb_count_monitor;

    logic       clk;
    logic       R;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_count;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [3:0] expected;

    int errors = 0;
    int checks = 0;

    count_monitor #(.W(4), .LOCK_N(2), .CNT_W(8)) dut (
        .clk       (clk),
        .R         (R),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .wrap_cnt  (wrap_cnt),
        .expected  (expected)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic v, input logic [3:0] c);
        in_valid = v;
        in_count = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        R = 1'b0; clr = 1'b0; in_valid = 1'b1; in_count = 4'd5;
        #29;
        checks++;
        if (locked !== 1'b0) begin
            $display("FAIL reset_locked got=%b want=0", locked); errors++;
        end
        checks++;
        if (err_cnt !== 8'd0 || wrap_cnt !== 8'd0) begin
            $display("FAIL reset_cnts got=%0d/%0d want=0/0", err_cnt, wrap_cnt);
            errors++;
        end
        checks++;
        if (expected !== 4'd0 || err_pulse !== 1'b0) begin
            $display("FAIL reset_exp got=%0d/%b want=0/0", expected, err_pulse);
            errors++;
        end
        #1;
        in_valid = 1'b0;
        R = 1'b1;
    endtask

    task automatic test_lock;
        drive(1'b1, 4'd5);
        checks++;
        if (locked !== 1'b0 || expected !== 4'd6) begin
            $display("FAIL lock_s5 got=%b/%0d want=0/6", locked, expected); errors++;
        end
        drive(1'b1, 4'd6);
        checks++;
        if (locked !== 1'b0 || expected !== 4'd7) begin
            $display("FAIL lock_s6 got=%b/%0d want=0/7", locked, expected); errors++;
        end
        drive(1'b1, 4'd7);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 8'd0 || expected !== 4'd8) begin
            $display("FAIL lock_s7 got=%b/%0d/%0d want=1/0/8", locked, err_cnt, expected);
            errors++;
        end
    endtask

    task automatic test_wrap;
        int pulses;
        pulses = 0;
        for (int v = 8; v <= 15; v++) begin
            drive(1'b1, 4'(v));
            if (err_pulse) pulses++;
        end
        checks++;
        if (wrap_cnt !== 8'd0) begin
            $display("FAIL wrap_pre got=%0d want=0", wrap_cnt); errors++;
        end
        drive(1'b1, 4'd0);
        if (err_pulse) pulses++;
        checks++;
        if (wrap_cnt !== 8'd1) begin
            $display("FAIL wrap_after0 got=%0d want=1", wrap_cnt); errors++;
        end
        drive(1'b1, 4'd1);
        if (err_pulse) pulses++;
        checks++;
        if (expected !== 4'd2 || locked !== 1'b1 || wrap_cnt !== 8'd1) begin
            $display("FAIL wrap_end got=%0d/%b/%0d want=2/1/1", expected, locked, wrap_cnt);
            errors++;
        end
        checks++;
        if (pulses !== 0 || err_cnt !== 8'd0) begin
            $display("FAIL wrap_noerr got=%0d/%0d want=0/0", pulses, err_cnt); errors++;
        end
    endtask

    task automatic test_glitch;
        drive(1'b1, 4'd2);
        drive(1'b1, 4'd3);
        drive(1'b1, 4'd4);
        checks++;
        if (err_pulse !== 1'b0 || locked !== 1'b1) begin
            $display("FAIL glitch_pre got=%b/%b want=0/1", err_pulse, locked); errors++;
        end
        drive(1'b1, 4'd9);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            $display("FAIL glitch_9 got=%b/%0d/%b want=1/1/0", err_pulse, err_cnt, locked);
            errors++;
        end
        checks++;
        if (expected !== 4'd10) begin
            $display("FAIL glitch_resync got=%0d want=10", expected); errors++;
        end
        drive(1'b1, 4'd10);
        checks++;
        if (err_pulse !== 1'b0 || err_cnt !== 8'd1 || locked !== 1'b1) begin
            $display("FAIL glitch_10 got=%b/%0d/%b want=0/1/1", err_pulse, err_cnt, locked);
            errors++;
        end
    endtask

    task automatic test_double_fault;
        drive(1'b1, 4'd11);
        drive(1'b1, 4'd9);
        checks++;
        if (err_cnt !== 8'd2 || err_pulse !== 1'b1) begin
            $display("FAIL dbl_first got=%0d/%b want=2/1", err_cnt, err_pulse); errors++;
        end
        drive(1'b1, 4'd2);
        checks++;
        if (err_cnt !== 8'd3 || err_pulse !== 1'b1 || locked !== 1'b0) begin
            $display("FAIL dbl_second got=%0d/%b/%b want=3/1/0", err_cnt, err_pulse, locked);
            errors++;
        end
        checks++;
        if (expected !== 4'd3) begin
            $display("FAIL dbl_exp got=%0d want=3", expected); errors++;
        end
        drive(1'b1, 4'd3);
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
            $display("FAIL dbl_relock1 got=%b/%b want=0/0", locked, err_pulse); errors++;
        end
        drive(1'b1, 4'd4);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 8'd3) begin
            $display("FAIL dbl_relock2 got=%b/%0d want=1/3", locked, err_cnt); errors++;
        end
    endtask

    task automatic test_gaps;
        int pulses;
        pulses = 0;
        drive(1'b1, 4'd5);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd9);
            if (err_pulse) pulses++;
        end
        checks++;
        if (pulses !== 0 || expected !== 4'd6 || locked !== 1'b1) begin
            $display("FAIL gap_idle got=%0d/%0d/%b want=0/6/1", pulses, expected, locked);
            errors++;
        end
        drive(1'b1, 4'd6);
        checks++;
        if (err_pulse !== 1'b0 || err_cnt !== 8'd3 || expected !== 4'd7) begin
            $display("FAIL gap_resume got=%b/%0d/%0d want=0/3/7", err_pulse, err_cnt, expected);
            errors++;
        end
    endtask

    task automatic test_clr;
        clr = 1'b1;
        drive(1'b1, 4'd3);
        clr = 1'b0;
        checks++;
        if (err_cnt !== 8'd0 || wrap_cnt !== 8'd0) begin
            $display("FAIL clr_cnts got=%0d/%0d want=0/0", err_cnt, wrap_cnt); errors++;
        end
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
            $display("FAIL clr_state got=%b/%b want=0/0", locked, err_pulse); errors++;
        end
        drive(1'b1, 4'd9);
        checks++;
        if (expected !== 4'd10 || err_cnt !== 8'd0 || locked !== 1'b0) begin
            $display("FAIL clr_first got=%0d/%0d/%b want=10/0/0", expected, err_cnt, locked);
            errors++;
        end
        drive(1'b1, 4'd10);
        drive(1'b1, 4'd11);
        checks++;
        if (locked !== 1'b1) begin
            $display("FAIL clr_relock got=%b want=1", locked); errors++;
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 4'd3);
        checks++;
        if (err_cnt !== 8'd1 || err_pulse !== 1'b1) begin
            $display("FAIL ar_pre got=%0d/%b want=1/1", err_cnt, err_pulse); errors++;
        end
        #2;
        R = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== 8'd0) begin
            $display("FAIL ar_mid got=%b/%b/%0d want=0/0/0", locked, err_pulse, err_cnt);
            errors++;
        end
        checks++;
        if (wrap_cnt !== 8'd0 || expected !== 4'd0) begin
            $display("FAIL ar_mid2 got=%0d/%0d want=0/0", wrap_cnt, expected); errors++;
        end
        @(negedge clk);
        R = 1'b1;
    endtask

    task automatic test_saturation;
        logic [3:0] e;
        logic [3:0] bad;
        logic [3:0] good;
        clr = 1'b1;
        drive(1'b0, 4'd0);
        clr = 1'b0;
        drive(1'b1, 4'd0);
        drive(1'b1, 4'd1);
        drive(1'b1, 4'd2);
        e = 4'd3;
        for (int i = 1; i <= 256; i++) begin
            bad  = e + 4'd5;
            good = e + 4'd6;
            drive(1'b1, bad);
            if (i == 254) begin
                checks++;
                if (err_cnt !== 8'd254) begin
                    $display("FAIL sat_254 got=%0d want=254", err_cnt); errors++;
                end
            end
            if (i == 256) begin
                checks++;
                if (err_cnt !== 8'd255 || err_pulse !== 1'b1) begin
                    $display("FAIL sat_hold got=%0d/%b want=255/1", err_cnt, err_pulse);
                    errors++;
                end
            end
            drive(1'b1, good);
            e = good + 4'd1;
        end
        checks++;
        if (locked !== 1'b1 || expected !== e) begin
            $display("FAIL sat_track got=%b/%0d want=1/%0d", locked, expected, e);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_glitch();
        test_double_fault();
        test_gaps();
        test_clr();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
